// File: rtl/bridge_buf_pkg.sv
// Shared types and sizing helpers for the west/north bridge buffer sequencer.
package bridge_buf_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READ,
      S_FLUSH,
      S_DONE
   } buf_state_t;

   // Number of slice beats replayed per READ phase.
   function automatic int bridge_steps(input int depth, input int modules);
      return depth * modules;
   endfunction

   // Width of a select that ranges over n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bridge_slice_addr_gen.sv
// Nested slice/address counter for one buffer side: the slice index counts 0..MODULES-1,
// and the read address advances each time the slice index wraps.
module bridge_slice_addr_gen
   import bridge_buf_pkg::*;
#(
   parameter  int MODULES    = 4,
   parameter  int ADDR_WIDTH = 8,
   localparam int SW         = idx_width(MODULES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  inc,
   output logic [SW-1:0]         slice_idx,
   output logic [ADDR_WIDTH-1:0] addr
);

   logic wrap;

   assign wrap = (slice_idx == SW'(MODULES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         slice_idx <= '0;
         addr      <= '0;
      end else if (inc) begin
         if (wrap) begin
            slice_idx <= '0;
            addr      <= addr + 1'b1;
         end else begin
            slice_idx <= slice_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bridge_buffer_ctrl.sv
// LOAD/READ sequencer for the bank-0 west/north bridge buffer pair.
// Define BRIDGE_BUF_CTRL_PERF_EN to add the stall_cnt/load_cyc performance counters.
module bridge_buffer_ctrl
   import bridge_buf_pkg::*;
#(
   parameter  int W_TOTAL_MODULES = 4,
   parameter  int N_TOTAL_MODULES = 4,
   parameter  int W_TOTAL_DEPTH   = 12,
   parameter  int N_TOTAL_DEPTH   = 12,
   parameter  int ADDR_WIDTH_W    = 8,
   parameter  int ADDR_WIDTH_N    = 8,
   localparam int W_SW            = idx_width(W_TOTAL_MODULES),
   localparam int N_SW            = idx_width(N_TOTAL_MODULES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic                    w_in_valid,
   output logic                    w_in_ready,
   input  logic                    n_in_valid,
   output logic                    n_in_ready,
   output logic                    w_bank0_ena,
   output logic                    w_bank0_wea,
   output logic [ADDR_WIDTH_W-1:0] w_bank0_addra,
   output logic                    w_bank0_enb,
   output logic [ADDR_WIDTH_W-1:0] w_bank0_addrb,
   output logic                    n_bank0_ena,
   output logic                    n_bank0_wea,
   output logic [ADDR_WIDTH_N-1:0] n_bank0_addra,
   output logic                    n_bank0_enb,
   output logic [ADDR_WIDTH_N-1:0] n_bank0_addrb,
   output logic [W_SW-1:0]         w_slicing_idx,
   output logic [N_SW-1:0]         n_slicing_idx,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef BRIDGE_BUF_CTRL_PERF_EN
   ,
   output logic [31:0]             stall_cnt,
   output logic [31:0]             load_cyc
`endif
);

   localparam int STEPS = bridge_steps(W_TOTAL_DEPTH, W_TOTAL_MODULES);
   localparam int WC_W  = $clog2(W_TOTAL_DEPTH + 1);
   localparam int NC_W  = $clog2(N_TOTAL_DEPTH + 1);
   localparam int ST_W  = $clog2(STEPS + 1);

   if (W_TOTAL_DEPTH * W_TOTAL_MODULES != N_TOTAL_DEPTH * N_TOTAL_MODULES) begin : g_steps_check
      $error("bridge_buffer_ctrl: west and north slice-step totals differ");
   end

   buf_state_t              state, state_nxt;
   logic [WC_W-1:0]         w_wr_cnt;
   logic [NC_W-1:0]         n_wr_cnt;
   logic [ST_W-1:0]         step_cnt;
   logic                    w_write, n_write, issue;
   logic [W_SW-1:0]         w_sl;
   logic [N_SW-1:0]         n_sl;
   logic [ADDR_WIDTH_W-1:0] w_rd_addr;
   logic [ADDR_WIDTH_N-1:0] n_rd_addr;

   // NOTE: every signal driven here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      w_in_ready = 1'b0;
      n_in_ready = 1'b0;
      w_write    = 1'b0;
      n_write    = 1'b0;
      issue      = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            w_in_ready = (w_wr_cnt < WC_W'(W_TOTAL_DEPTH));
            n_in_ready = (n_wr_cnt < NC_W'(N_TOTAL_DEPTH));
            w_write    = w_in_valid && w_in_ready;
            n_write    = n_in_valid && n_in_ready;
            // Look at post-write counts so beats landing this cycle complete the load.
            if ((w_wr_cnt + WC_W'(w_write) == WC_W'(W_TOTAL_DEPTH)) &&
                (n_wr_cnt + NC_W'(n_write) == NC_W'(N_TOTAL_DEPTH)))
               state_nxt = S_READ;
         end
         S_READ: begin
            issue = out_ready;
            if (issue && step_cnt == ST_W'(STEPS - 1)) state_nxt = S_FLUSH;
         end
         S_FLUSH: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign w_bank0_ena   = w_write;
   assign w_bank0_wea   = w_write;
   assign w_bank0_addra = w_write ? ADDR_WIDTH_W'(w_wr_cnt) : '0;
   assign n_bank0_ena   = n_write;
   assign n_bank0_wea   = n_write;
   assign n_bank0_addra = n_write ? ADDR_WIDTH_N'(n_wr_cnt) : '0;
   assign w_bank0_enb   = issue;
   assign w_bank0_addrb = issue ? w_rd_addr : '0;
   assign n_bank0_enb   = issue;
   assign n_bank0_addrb = issue ? n_rd_addr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         w_wr_cnt      <= '0;
         n_wr_cnt      <= '0;
         step_cnt      <= '0;
         out_valid     <= 1'b0;
         w_slicing_idx <= '0;
         n_slicing_idx <= '0;
      end else begin
         state         <= state_nxt;
         out_valid     <= issue;
         w_slicing_idx <= issue ? w_sl : '0;
         n_slicing_idx <= issue ? n_sl : '0;
         if (state == S_IDLE) begin
            w_wr_cnt <= '0;
            n_wr_cnt <= '0;
            step_cnt <= '0;
         end else begin
            if (w_write) w_wr_cnt <= w_wr_cnt + 1'b1;
            if (n_write) n_wr_cnt <= n_wr_cnt + 1'b1;
            if (issue)   step_cnt <= step_cnt + 1'b1;
         end
      end
   end

   bridge_slice_addr_gen #(.MODULES(W_TOTAL_MODULES), .ADDR_WIDTH(ADDR_WIDTH_W)) u_w_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == S_IDLE),
      .inc       (issue),
      .slice_idx (w_sl),
      .addr      (w_rd_addr)
   );

   bridge_slice_addr_gen #(.MODULES(N_TOTAL_MODULES), .ADDR_WIDTH(ADDR_WIDTH_N)) u_n_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == S_IDLE),
      .inc       (issue),
      .slice_idx (n_sl),
      .addr      (n_rd_addr)
   );

`ifdef BRIDGE_BUF_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || (state == S_IDLE && start)) begin
         stall_cnt <= '0;
         load_cyc  <= '0;
      end else begin
         if (state == S_LOAD && load_cyc != '1)                stall_cnt <= stall_cnt;
         if (state == S_LOAD && load_cyc != '1)                load_cyc  <= load_cyc + 1'b1;
         if (state == S_READ && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// Directed self-checking bench for bridge_buffer_ctrl (default 4x12 geometry, 48 steps).
module tb_bridge_buffer_ctrl;

   localparam int DEPTH = 12;
   localparam int MODS  = 4;
   localparam int STEPS = DEPTH * MODS;

   logic       clk = 1'b0;
   logic       rst, start, w_in_valid, n_in_valid, out_ready;
   logic       busy, done, w_in_ready, n_in_ready, out_valid;
   logic       w_bank0_ena, w_bank0_wea, w_bank0_enb;
   logic       n_bank0_ena, n_bank0_wea, n_bank0_enb;
   logic [7:0] w_bank0_addra, w_bank0_addrb, n_bank0_addra, n_bank0_addrb;
   logic [1:0] w_slicing_idx, n_slicing_idx;
`ifdef BRIDGE_BUF_CTRL_PERF_EN
   logic [31:0] stall_cnt, load_cyc;
`endif

   int n_vec = 0;
   int n_err = 0;

   bridge_buffer_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .w_in_valid    (w_in_valid),
      .w_in_ready    (w_in_ready),
      .n_in_valid    (n_in_valid),
      .n_in_ready    (n_in_ready),
      .w_bank0_ena   (w_bank0_ena),
      .w_bank0_wea   (w_bank0_wea),
      .w_bank0_addra (w_bank0_addra),
      .w_bank0_enb   (w_bank0_enb),
      .w_bank0_addrb (w_bank0_addrb),
      .n_bank0_ena   (n_bank0_ena),
      .n_bank0_wea   (n_bank0_wea),
      .n_bank0_addra (n_bank0_addra),
      .n_bank0_enb   (n_bank0_enb),
      .n_bank0_addrb (n_bank0_addrb),
      .w_slicing_idx (w_slicing_idx),
      .n_slicing_idx (n_slicing_idx),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
`ifdef BRIDGE_BUF_CTRL_PERF_EN
      ,
      .stall_cnt     (stall_cnt),
      .load_cyc      (load_cyc)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, 32'({busy, done, w_in_ready, n_in_ready, out_valid}), 32'd0);
      check({tag, "_w"}, 32'({w_bank0_ena, w_bank0_wea, w_bank0_addra, w_bank0_enb, w_bank0_addrb}), 32'd0);
      check({tag, "_n"}, 32'({n_bank0_ena, n_bank0_wea, n_bank0_addra, n_bank0_enb, n_bank0_addrb}), 32'd0);
      check({tag, "_idx"}, 32'({w_slicing_idx, n_slicing_idx}), 32'd0);
   endtask

   // Starts from IDLE; W valid held high, N pauses for pause_len cycles once it has n_pause_at beats.
   task automatic load_phase(input int n_pause_at, input int pause_len);
      int wc = 0;
      int nc = 0;
      int pause = 0;
      start = 1'b1;
      step();
      start     = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && !(wc == DEPTH && nc == DEPTH); cyc++) begin
         w_in_valid = 1'b1;
         n_in_valid = !(nc == n_pause_at && pause < pause_len);
         if (!n_in_valid) pause++;
         @(negedge clk);
         check("w_in_ready", 32'(w_in_ready), 32'(wc < DEPTH));
         check("w_ena", 32'({w_bank0_ena, w_bank0_wea}), (wc < DEPTH) ? 32'd3 : 32'd0);
         if (wc < DEPTH) check("w_addra", 32'(w_bank0_addra), 32'(wc));
         check("n_in_ready", 32'(n_in_ready), 32'(nc < DEPTH));
         check("n_ena", 32'({n_bank0_ena, n_bank0_wea}), (n_in_valid && nc < DEPTH) ? 32'd3 : 32'd0);
         if (n_in_valid && nc < DEPTH) check("n_addra", 32'(n_bank0_addra), 32'(nc));
         check("load_no_enb", 32'({w_bank0_enb, n_bank0_enb}), 32'd0);
         check("load_busy", 32'(busy), 32'd1);
         if (wc < DEPTH) wc++;
         if (n_in_valid && nc < DEPTH) nc++;
         step();
      end
      check("load_beats", 32'(wc + nc), 32'(2 * DEPTH));
      w_in_valid = 1'b0;
      n_in_valid = 1'b0;
   endtask

   // Entered on the first READ cycle. mode 0: ready always; 1: ready on even cycles; 2: 10 stalls first.
   task automatic run_read(input int mode);
      int issues = 0;
      int vcnt = 0;
      int last_issue = -1;
      int done_cyc = -1;
      int done_cnt = 0;
      bit prev_issue = 1'b0;
      bit exp_issue;
      bit ended = 1'b0;
      for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
         case (mode)
            1:       out_ready = (cyc % 2 == 0);
            2:       out_ready = (cyc >= 10);
            default: out_ready = 1'b1;
         endcase
         start = (mode == 0 && cyc == 5);
         @(negedge clk);
         if (done_cnt > 0 && !busy) begin
            ended = 1'b1;
         end else begin
            exp_issue = out_ready && issues < STEPS;
            check("enb", 32'({w_bank0_enb, n_bank0_enb}), exp_issue ? 32'd3 : 32'd0);
            if (exp_issue) begin
               check("w_addrb", 32'(w_bank0_addrb), 32'(issues / MODS));
               check("n_addrb", 32'(n_bank0_addrb), 32'(issues / MODS));
               issues++;
               last_issue = cyc;
            end
            check("out_valid", 32'(out_valid), 32'(prev_issue));
            if (prev_issue) begin
               check("w_idx", 32'(w_slicing_idx), 32'(vcnt % MODS));
               check("n_idx", 32'(n_slicing_idx), 32'(vcnt % MODS));
               vcnt++;
            end
            check("no_write_in_read", 32'({w_bank0_ena, n_bank0_ena}), 32'd0);
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            prev_issue = exp_issue;
            step();
         end
      end
      start     = 1'b0;
      out_ready = 1'b0;
      check("read_ended", 32'(ended), 32'd1);
      check("issues", 32'(issues), 32'(STEPS));
      check("valid_beats", 32'(vcnt), 32'(STEPS));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("done_latency", 32'(done_cyc - last_issue), 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      w_in_valid = 1'b0;
      n_in_valid = 1'b0;
      out_ready  = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;
      step();

      // Full load with both sides streaming, then an unstalled replay.
      load_phase(DEPTH, 0);
      run_read(0);

      // Replay with out_ready alternating.
      load_phase(DEPTH, 0);
      run_read(1);

      // North stalls after 5 beats while west completes.
      load_phase(5, 3);
      run_read(0);

      // Reset in the middle of READ at step 20.
      load_phase(DEPTH, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("pre_abort_addrb", 32'(w_bank0_addrb), 32'(i / MODS));
         check("pre_abort_done", 32'(done), 32'd0);
         step();
      end
      rst       = 1'b1;
      out_ready = 1'b0;
      step();
      @(negedge clk);
      check_quiet("abort");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_done", 32'({done, busy}), 32'd0);
      end
      load_phase(DEPTH, 0);
      run_read(0);

`ifdef BRIDGE_BUF_CTRL_PERF_EN
      load_phase(DEPTH, 0);
      run_read(2);
      @(negedge clk);
      check("stall_cnt", stall_cnt, 32'd10);
      check("load_cyc", load_cyc, 32'(DEPTH));
      step();
      load_phase(DEPTH, 0);
      check("stall_cleared", stall_cnt, 32'd0);
      check("load_cyc_again", load_cyc, 32'(DEPTH));
      run_read(0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
